ifu_pc_stage: RTL

// Fetch-stage PC register plus IF/ID pipeline register for the 5-stage MIPS core.

---
 rtl/ifu_pc_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/ifu_pc_stage.sv
// Fetch-stage PC register and IF/ID pipeline register for the 5-stage MIPS core.
// Forms the next PC from pc_op and the D-stage operands, and flags fetch address errors.
module ifu_pc_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LOW   = 32'h0000_3000,
    parameter logic [31:0] PC_HIGH  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  pc_op,
    input  logic [15:0] imm16_d,
    input  logic [25:0] instr_index_d,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        adel_d
);

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_JREG   = 2'b11
    } pc_op_e;

    pc_op_e      op;
    logic [31:0] npc;
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;
    logic        adel_f;

    assign op = pc_op_e'(pc_op);

    // Branch and jump bases are the branch's own PC (pc_d); F currently holds the delay slot.
    always_comb begin
        seq_pc     = pc_f + 32'd4;
        branch_off = {{14{imm16_d[15]}}, imm16_d, 2'b00};
        branch_pc  = pc_d + 32'd4 + branch_off;
        jump_pc    = {pc_d[31:28], instr_index_d, 2'b00};
        npc        = seq_pc;
        unique case (op)
            PC_SEQ:    npc = seq_pc;
            PC_BRANCH: npc = branch_pc;
            PC_JUMP:   npc = jump_pc;
            PC_JREG:   npc = jr_target;
            default:   npc = seq_pc;
        endcase
    end

    always_comb begin
        adel_f = (pc_f[1:0] != 2'b00) | (pc_f < PC_LOW) | (pc_f > PC_HIGH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f <= PC_RESET;
        end else if (!stall) begin
            pc_f <= npc;
        end
    end

    // A faulting fetch still advances into D, but as a nop with the fault flag attached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_d <= '0;
            pc_d    <= '0;
            pc8_d   <= '0;
            adel_d  <= 1'b0;
        end else if (!stall) begin
            instr_d <= adel_f ? 32'h0000_0000 : instr_f;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            adel_d  <= adel_f;
        end
    end

endmodule
